marker_payload_capture: RTL and testbench
=========================================

// Module: marker_payload_capture
// PURPOSE
//  Downstream of the serial marker detector ("11110" Moore detector). It consumes the
//  detector's one-cycle hit pulse and the same serial bit stream x.
//  After each hit it captures the next PAYLOAD_W bits MSB-first into a parallel word.
//  It presents that word on a valid/ready output port and counts markers it could not
//  service. Both this block and the detector sample x on every rising clk edge.
// PARAMETERS
//  PAYLOAD_W  8  payload bits captured after each marker (legal range >= 1)
//  CNT_W      8  width of the saturating dropped-marker counter
// PORTS
//  clk        in   1          rising-edge clock, shared with the detector
//  reset      in   1          synchronous, active-high
//  x          in   1          serial bit stream, the same signal that feeds the detector
//  hit        in   1          detector z output; high in the cycle whose x is payload bit 0
//  data_out   out  PAYLOAD_W  captured payload; first bit received is in [PAYLOAD_W-1]
//  out_valid  out  1          data_out is valid and held stable until accepted
//  out_ready  in   1          consumer accepts the word when out_valid && out_ready
//  busy       out  1          high while in the CAPTURE state
//  drop_cnt   out  CNT_W      number of hits ignored in HOLD; saturates at all-ones
//  overrun    out  1          sticky; set by the first dropped hit, cleared only by reset
// BEHAVIOUR
//  Reset (sync, active-high, priority over all other inputs, may assert in any state):
//   - state goes to IDLE; the bit counter goes to 0.
//   - data_out=0, out_valid=0, busy=0, drop_cnt=0, overrun=0.
//   - Any partial capture is discarded.
//  All outputs are registered. States: IDLE, CAPTURE, HOLD.
//  IDLE:
//   - hit=0: stay in IDLE.
//   - hit=1: shift x in as bit 0 and set cnt=1.
//   - Go to CAPTURE, or to HOLD with out_valid=1 if PAYLOAD_W==1.
//  CAPTURE:
//   - Every cycle: shreg <= {shreg[PAYLOAD_W-2:0], x} and cnt increments.
//   - On the cycle that shifts bit PAYLOAD_W-1 in, load data_out and go to HOLD.
//   - hit is ignored here: payload bits may alias the marker.
//   - Ignored hits are not counted as drops.
//  HOLD:
//   - out_valid=1 and data_out is stable.
//   - out_ready=1 completes the transfer: out_valid drops on the next cycle and state
//     goes to IDLE.
//   - hit=1 with out_ready=0: the marker is dropped; drop_cnt increments (saturating)
//     and overrun is set; stay in HOLD.
//   - hit=1 with out_ready=1 in the same cycle: the transfer completes and x is taken
//     as bit 0 of a new capture; go to CAPTURE; this is not a drop.
//   - With PAYLOAD_W==1 in that case, reload data_out and stay in HOLD with out_valid=1.
//  Latency:
//   - hit in cycle N means the last payload bit is sampled in cycle N+PAYLOAD_W-1.
//   - out_valid is high from cycle N+PAYLOAD_W onward.
//   - Best-case throughput: one word per PAYLOAD_W cycles, when out_ready is asserted
//     on the first HOLD cycle.
//  Widths:
//   - cnt is $clog2(PAYLOAD_W+1) bits wide.
//   - drop_cnt holds at {CNT_W{1'b1}} and never wraps.
//   - data_out is only updated on the HOLD load.
// STRUCTURE
//  - Shared include capture_defs.vh holds:
//    - state encodings ST_IDLE=2'd0, ST_CAPTURE=2'd1, ST_HOLD=2'd2
//    - default PAYLOAD_W and CNT_W values
//  - Unused state encoding 2'd3 recovers to IDLE.
//  - One sub-module: sat_counter #(W) (inc, clr -> q, saturating), which implements drop_cnt.
//  - The FSM, shift register and bit counter are inline in this module.
// TESTING
//  Use the default parameters (PAYLOAD_W=8, CNT_W=8).
//  1. Basic capture: x=11110 then 10100110, out_ready=1
//     -> hit is followed 8 cycles later by out_valid for 1 cycle with data_out=8'hA6.
//  2. Backpressure: out_ready=0 for 5 cycles after out_valid
//     -> data_out holds 8'hA6 and out_valid stays high; it drops the cycle after
//        out_ready=1.
//  3. Dropped marker: in HOLD with out_ready=0, drive a second 11110 marker
//     -> drop_cnt=1 and overrun=1; data_out is unchanged.
//  4. Aliasing: payload 11110xxx inside CAPTURE (the hit pulse fires)
//     -> no restart; data_out=8'hF0|xxx; drop_cnt stays 0.
//  5. Simultaneous events: hit and out_ready in the same HOLD cycle
//     -> the old word is accepted and the new word arrives 8 cycles later; no drop.
//  6. Reset mid-CAPTURE after 4 bits
//     -> the next cycle shows all outputs 0 and state IDLE; the next marker captures
//        cleanly.

Source files
------------

// File: rtl/marker_payload_capture_pkg.sv
// marker_payload_capture_pkg: state encodings and default parameters for the marker payload capture block
package marker_payload_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int DEF_PAYLOAD_W = 8;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/marker_payload_capture_sat_counter.sv
// sat_counter: up-counter that holds at all-ones and clears synchronously
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // clear wins, otherwise count up until the value is all-ones
    always_comb q_d = clr ? '0 : (inc && q_q != '1) ? q_q + W'(1) : q_q;

    // counter register
    always_ff @(posedge clk) q_q <= q_d;

    assign q = q_q;

endmodule

// File: rtl/marker_payload_capture.sv
// marker_payload_capture: captures PAYLOAD_W serial bits after each marker hit and offers them on a valid/ready port
module marker_payload_capture
    import marker_payload_capture_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 hit,
    output logic [PAYLOAD_W-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 overrun
);

    localparam int CW = $clog2(PAYLOAD_W + 1);
    localparam int SW = PAYLOAD_W > 1 ? PAYLOAD_W - 1 : 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_W - 1);
    localparam bit ONEBIT = PAYLOAD_W == 1;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          shreg_q, shreg_d;
    logic [PAYLOAD_W-1:0]   data_q, data_d;
    logic [PAYLOAD_W-1:0]   shifted;
    logic                   overrun_q, overrun_d;
    logic                   start;
    logic                   drop;

    if (ONEBIT) begin : g_one
        assign shifted = x;
    end else begin : g_wide
        assign shifted = {shreg_q, x};
    end

    assign start = hit && (state_q == ST_IDLE || (state_q == ST_HOLD && out_ready));
    assign drop  = hit && state_q == ST_HOLD && !out_ready;

    // next-state, shift register, bit counter and output word
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        overrun_d = overrun_q | drop;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CAPTURE: begin
                shreg_d = shifted[SW-1:0];
                cnt_d   = cnt_q + ONE;
                data_d  = cnt_q == LAST ? shifted : data_q;
                state_d = cnt_q == LAST ? ST_HOLD : ST_CAPTURE;
            end
            ST_HOLD: state_d = out_ready ? ST_IDLE : ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            shreg_d = shifted[SW-1:0];
            cnt_d   = ONE;
            data_d  = ONEBIT ? shifted : data_d;
            state_d = ONEBIT ? ST_HOLD : ST_CAPTURE;
        end
        if (reset) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            shreg_d   = '0;
            data_d    = '0;
            overrun_d = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        shreg_q   <= shreg_d;
        data_q    <= data_d;
        overrun_q <= overrun_d;
    end

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .clr (reset),
        .inc (drop),
        .q   (drop_cnt)
    );

    assign data_out  = data_q;
    assign out_valid = state_q == ST_HOLD;
    assign busy      = state_q == ST_CAPTURE;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_marker_payload_capture.sv
// tb_marker_payload_capture: directed scenarios plus random traffic against a transaction-level model
module tb_marker_payload_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       hit = 1'b0;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       overrun;

    int         tests = 0;
    int         fails = 0;
    logic [4:0] hist = '0;

    logic       m_cap = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_data = '0;
    int         m_bits = 0;
    int         m_drop = 0;

    marker_payload_capture dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .hit       (hit),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input logic xi, input logic ri, input logic rsti);
        logic h;
        h = hist == 5'b11110;
        x = xi;
        out_ready = ri;
        reset = rsti;
        hit = h;
        @(posedge clk);
        if (rsti) begin
            m_cap = 0; m_valid = 0; m_data = '0; m_drop = 0; m_ovr = 0; m_bits = 0;
        end else if (m_cap) begin
            m_acc = {m_acc[6:0], xi};
            m_bits++;
            if (m_bits == 8) begin m_data = m_acc; m_valid = 1; m_cap = 0; end
        end else if (m_valid && ri) begin
            m_valid = 0;
            if (h) begin m_cap = 1; m_acc = {7'b0, xi}; m_bits = 1; end
        end else if (m_valid && h) begin
            m_ovr = 1;
            if (m_drop < 255) m_drop++;
        end else if (!m_valid && h) begin
            m_cap = 1; m_acc = {7'b0, xi}; m_bits = 1;
        end
        hist = {hist[3:0], xi};
        #1;
    endtask

    task automatic send(input logic [31:0] bits, input int n, input logic ri);
        for (int i = n - 1; i >= 0; i--) step(bits[i], ri, 1'b0);
    endtask

    task automatic test_reset;
        step(0, 0, 1);
        step(0, 0, 1);
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", data_out); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (drop_cnt !== 8'h00) begin fails++; $display("FAIL reset_drop got %h want 00", drop_cnt); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        step(0, 0, 0);
    endtask

    task automatic test_basic;
        send(5'b11110, 5, 1);
        send(7'b1010011, 7, 1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        send(1'b0, 1, 1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
        tests++; if (data_out !== 8'hA6) begin fails++; $display("FAIL basic_data got %h want a6", data_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", busy); end
        step(0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_accept got %b want 0", out_valid); end
    endtask

    task automatic test_alias;
        send(5'b11110, 5, 1);
        send(8'hF5, 8, 1);
        tests++; if (data_out !== 8'hF5) begin fails++; $display("FAIL alias_data got %h want f5", data_out); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL alias_valid got %b want 1", out_valid); end
        tests++; if (drop_cnt !== 8'h00) begin fails++; $display("FAIL alias_drop got %h want 00", drop_cnt); end
        step(0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL alias_accept got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        send(5'b11110, 5, 1);
        send(8'hA6, 8, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            tests++; if (data_out !== 8'hA6) begin fails++; $display("FAIL bp_data[%0d] got %h want a6", i, data_out); end
        end
        step(0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", out_valid); end
    endtask

    task automatic test_drop;
        send(5'b11110, 5, 0);
        send(8'hA6, 8, 0);
        send(5'b11110, 5, 0);
        step(0, 0, 0);
        tests++; if (drop_cnt !== 8'h01) begin fails++; $display("FAIL drop_cnt got %h want 01", drop_cnt); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL drop_overrun got %b want 1", overrun); end
        tests++; if (data_out !== 8'hA6) begin fails++; $display("FAIL drop_data got %h want a6", data_out); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drop_valid got %b want 1", out_valid); end
        step(0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drop_accept got %b want 0", out_valid); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL drop_sticky got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back;
        send(5'b11110, 5, 0);
        send(8'hA6, 8, 0);
        send(5'b11110, 5, 0);
        step(0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_accept got %b want 0", out_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy); end
        tests++; if (drop_cnt !== 8'h01) begin fails++; $display("FAIL b2b_nodrop got %h want 01", drop_cnt); end
        send(7'b0111100, 7, 1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL b2b_data got %h want 3c", data_out); end
        step(0, 1, 0);
    endtask

    task automatic test_reset_mid;
        send(5'b11110, 5, 1);
        send(4'b1011, 4, 1);
        step(0, 1, 1);
        tests++; if ({data_out, out_valid, busy, drop_cnt, overrun} !== 19'h0) begin
            fails++; $display("FAIL midreset_outputs got %h/%b/%b/%h/%b want all 0", data_out, out_valid, busy, drop_cnt, overrun);
        end
        send(5'b11110, 5, 1);
        send(8'hC3, 8, 1);
        tests++; if (data_out !== 8'hC3) begin fails++; $display("FAIL midreset_data got %h want c3", data_out); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midreset_valid got %b want 1", out_valid); end
        step(0, 1, 0);
    endtask

    task automatic test_saturate;
        step(0, 0, 1);
        send(5'b11110, 5, 0);
        send(8'hA6, 8, 0);
        for (int i = 0; i < 300; i++) send(5'b11110, 5, 0);
        tests++; if (drop_cnt !== 8'hFF) begin fails++; $display("FAIL sat_cnt got %h want ff", drop_cnt); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL sat_overrun got %b want 1", overrun); end
        tests++; if (data_out !== 8'hA6) begin fails++; $display("FAIL sat_data got %h want a6", data_out); end
    endtask

    task automatic test_random;
        step(0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
            tests++;
            if ({data_out, out_valid, busy, drop_cnt, overrun} !== {m_data, m_valid, m_cap, 8'(m_drop), m_ovr}) begin
                fails++;
                $display("FAIL random[%0d] got d=%h v=%b b=%b c=%h o=%b want d=%h v=%b b=%b c=%h o=%b", i,
                         data_out, out_valid, busy, drop_cnt, overrun, m_data, m_valid, m_cap, 8'(m_drop), m_ovr);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_alias;
        test_backpressure;
        test_drop;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
